// File: rtl/mem_port_arbiter_if.sv
// Bundles the two requester ports and the memory macro port of the shared-memory arbiter.
// The slave view is the arbiter; the master view is the pipeline plus memory side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              if_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_stall;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              bus_err;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_done,
        output if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_done,
        input  if_rdata, if_done, if_stall, d_rdata, d_done, d_stall,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data load/store,
// with data priority, a fetch-starvation guard and a watchdog on hung accesses.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT        = 16
) (
    input logic               clk,
    input logic               rst_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, FETCH, DATA} state_e;

    localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);
    localparam logic [7:0] WD_LAST   = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic [7:0]        wd_cnt_q, wd_cnt_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              bus_err_q, bus_err_d;

    logic              if_done, d_done;
    logic [DATA_W-1:0] if_rdata, d_rdata;
    logic              mem_hit, timeout, grant_data, grant_fetch;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            wd_cnt_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        bus_err_d   = 1'b0;
        if_done     = 1'b0;
        d_done      = 1'b0;
        if_rdata    = '0;
        d_rdata     = '0;
        // mem_done only counts while an access is outstanding
        mem_hit     = bus.mem_done & mem_req_q;
        timeout     = (wd_cnt_q == WD_LAST) & ~mem_hit;
        grant_data  = bus.d_req & (~bus.if_req | (burst_cnt_q != BURST_MAX));
        grant_fetch = bus.if_req & ~grant_data;

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d     = DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    wd_cnt_d    = '0;
                    if (!bus.if_req)
                        burst_cnt_d = '0;
                    else if (burst_cnt_q != 4'd15)
                        burst_cnt_d = burst_cnt_q + 4'd1;
                end else if (grant_fetch) begin
                    state_d     = FETCH;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = bus.if_addr;
                    wd_cnt_d    = '0;
                    burst_cnt_d = '0;
                end
            end
            FETCH, DATA: begin
                if (mem_hit || timeout) begin
                    if (state_q == FETCH) begin
                        if_done  = 1'b1;
                        if_rdata = mem_hit ? bus.mem_rdata : '0;
                    end else begin
                        d_done  = 1'b1;
                        d_rdata = (mem_hit && !mem_we_q) ? bus.mem_rdata : '0;
                    end
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    bus_err_d = timeout;
                end else begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.if_done   = if_done;
    assign bus.if_rdata  = if_rdata;
    assign bus.d_done    = d_done;
    assign bus.d_rdata   = d_rdata;
    assign bus.if_stall  = bus.if_req & ~if_done;
    assign bus.d_stall   = bus.d_req & ~d_done;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small memory model and a done-pulse scoreboard.
module tb_mem_port_arbiter;

    typedef struct {
        bit          is_data;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_DATA_BURST(4), .TIMEOUT(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    // Memory model: completes mem_lat cycles after mem_req rises unless hung.
    int          mem_lat    = 0;
    bit          mem_hang   = 1'b0;
    bit          force_done = 1'b0;
    bit          rd_ovr_en  = 1'b0;
    logic [31:0] rd_ovr     = '0;
    int          mcnt       = 0;

    always @(posedge clk) begin
        if (!bus.mem_req || bus.mem_done) mcnt <= 0;
        else                              mcnt <= mcnt + 1;
    end

    always_comb begin
        bus.mem_done  = force_done | (bus.mem_req & ~mem_hang & (mcnt == mem_lat));
        bus.mem_rdata = rd_ovr_en ? rd_ovr : (bus.mem_addr ^ 32'hC0DE_0000);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input bit want_data, input int limit, output int n);
        bit got = 1'b0;
        n = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (want_data ? bus.d_done : bus.if_done) begin
                n   = i;
                got = 1'b1;
                break;
            end
        end
        if (!got) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    always @(negedge clk) begin
        if (bus.if_done || bus.d_done) begin
            chk("one_done", 32'(bus.if_done & bus.d_done), 32'd0);
            chk("sb_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("done_kind", 32'(bus.d_done), 32'(mon_e.is_data));
                chk("rdata", bus.d_done ? bus.d_rdata : bus.if_rdata, mon_e.rdata);
            end
        end
    end

    initial begin
        int n;
        int nd;
        bit got;

        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        tick(); tick();
        @(negedge clk);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_bus_err", 32'(bus.bus_err), 32'd0);
        chk("rst_dones", 32'({bus.if_done, bus.d_done}), 32'd0);
        chk("rst_rdata", bus.if_rdata | bus.d_rdata, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Spurious mem_done while idle
        force_done = 1'b1;
        @(negedge clk);
        chk("spur_dones", 32'({bus.if_done, bus.d_done}), 32'd0);
        tick();
        @(negedge clk);
        chk("spur_mem_req", 32'(bus.mem_req), 32'd0);
        force_done = 1'b0;

        // Single load, memory answers 2 cycles after mem_req
        tick();
        mem_lat = 2; rd_ovr_en = 1'b1; rd_ovr = 32'hDEADBEEF;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
        sb.push_back('{1'b1, 32'hDEADBEEF});
        @(negedge clk);
        chk("ld_idle_mem_req", 32'(bus.mem_req), 32'd0);
        chk("ld_stall", 32'(bus.d_stall), 32'd1);
        @(negedge clk);
        chk("ld_mem_req", 32'(bus.mem_req), 32'd1);
        chk("ld_mem_addr", bus.mem_addr, 32'h100);
        chk("ld_mem_we", 32'(bus.mem_we), 32'd0);
        wait_done("ld", 1'b1, 20, n);
        chk("ld_done_cycle", 32'(n), 32'd2);
        chk("ld_done_stall", 32'(bus.d_stall), 32'd0);
        tick();
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("ld_after_stall", 32'(bus.d_stall), 32'd0);
        chk("ld_after_mem_req", 32'(bus.mem_req), 32'd0);
        rd_ovr_en = 1'b0;

        // Store, memory answers 3 cycles after mem_req; mem_* must stay stable
        tick();
        mem_lat = 3;
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h12345678;
        sb.push_back('{1'b1, 32'h0});
        @(negedge clk);
        got = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            chk("st_mem_req", 32'(bus.mem_req), 32'd1);
            chk("st_mem_we", 32'(bus.mem_we), 32'd1);
            chk("st_mem_addr", bus.mem_addr, 32'h20);
            chk("st_mem_wdata", bus.mem_wdata, 32'h12345678);
            if (bus.d_done) begin
                chk("st_done_cycle", 32'(i), 32'd4);
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("st_timeout", 32'd0, 32'd1);
        tick();
        bus.d_req = 1'b0; bus.d_we = 1'b0;
        @(negedge clk);
        chk("st_after_done", 32'(bus.d_done), 32'd0);

        // Simultaneous requests at reset exit: four data grants then fetch
        tick();
        rst_n = 1'b0;
        mem_lat = 0;
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h80;
        for (int i = 0; i < 4; i++) sb.push_back('{1'b1, 32'hC0DE_0080});
        sb.push_back('{1'b0, 32'hC0DE_0040});
        tick();
        rst_n = 1'b1;
        nd = 0; n = 0; got = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (i == 1) chk("burst_both_stall", 32'({bus.if_stall, bus.d_stall}), 32'd3);
            if (bus.d_done) nd++;
            if (bus.if_done) begin
                n = i;
                got = 1'b1;
                break;
            end
        end
        chk("burst_fetch_served", 32'(got), 32'd1);
        chk("burst_data_grants", 32'(nd), 32'd4);
        chk("burst_fetch_latency_ok", 32'(n <= 15 && n > 0), 32'd1);
        tick();
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        @(negedge clk);
        chk("burst_idle", 32'(bus.mem_req), 32'd0);

        // Watchdog on a hung fetch
        tick();
        mem_hang = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h300;
        sb.push_back('{1'b0, 32'h0});
        @(negedge clk);
        wait_done("wd", 1'b0, 40, n);
        chk("wd_done_cycle", 32'(n), 32'd16);
        chk("wd_no_err_yet", 32'(bus.bus_err), 32'd0);
        tick();
        bus.if_req = 1'b0;
        @(negedge clk);
        chk("wd_bus_err", 32'(bus.bus_err), 32'd1);
        chk("wd_mem_req", 32'(bus.mem_req), 32'd0);
        tick();
        @(negedge clk);
        chk("wd_bus_err_pulse", 32'(bus.bus_err), 32'd0);
        mem_hang = 1'b0;

        // Reset two cycles into a data access, then a fresh fetch
        tick();
        mem_lat = 10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h44;
        @(negedge clk);
        @(negedge clk);
        chk("rm_mem_req", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        chk("rm_mem_req_drop", 32'(bus.mem_req), 32'd0);
        chk("rm_no_done", 32'(bus.d_done), 32'd0);
        chk("rm_mem_addr", bus.mem_addr, 32'd0);
        rst_n = 1'b1;
        tick();
        mem_lat = 1;
        bus.if_req = 1'b1; bus.if_addr = 32'h500;
        sb.push_back('{1'b0, 32'hC0DE_0500});
        @(negedge clk);
        wait_done("rm_fetch", 1'b0, 20, n);
        chk("rm_fetch_cycle", 32'(n), 32'd2);
        tick();
        bus.if_req = 1'b0;
        tick(); tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
